mlp_layer_sequencer: RTL

Top-level scheduler that sequences one PE through a multi-layer MLP pass, neuron by neuron. For every neuron it:
- waits for the weight loader to finish filling the idle ping-pong weight bank, then orders the bank swap;
- clears the accumulator, streams in_len input activations through a valid/ready handshake, and drives the activation read address;
- waits out the multiply/accumulate pipeline, then strobes out_valid.

Per-layer lengths are held in a small programmable configuration table.

---
 rtl/mlp_seq_pkg.sv | 22 ++
 rtl/mlp_cfg_regfile.sv | 51 +++++
 rtl/mlp_layer_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mlp_seq_pkg.sv
// Shared definitions for the MLP layer sequencer: FSM encoding, layer-index
// width helper and the default MAC pipeline latency.
package mlp_seq_pkg;

    localparam int PIPE_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIPCHK,
        S_WAIT_W,
        S_MAC,
        S_DRAIN,
        S_EMIT,
        S_LAYER_END
    } state_t;

    // Table index width; a one-layer table still needs a 1-bit index port.
    function automatic int layer_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_cfg_regfile.sv
// Per-layer configuration table {in_len, num_nrn}: synchronous write,
// combinational read, synchronous clear.
module mlp_cfg_regfile
    import mlp_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int LEN_W      = 8,
    parameter int NRN_W      = 8,
    localparam int LAYER_W   = layer_w(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [LAYER_W-1:0] wr_layer,
    input  logic [LEN_W-1:0]   wr_in_len,
    input  logic [NRN_W-1:0]   wr_num_nrn,
    input  logic [LAYER_W-1:0] rd_layer,
    output logic [LEN_W-1:0]   rd_in_len,
    output logic [NRN_W-1:0]   rd_num_nrn
);

    logic [LEN_W-1:0] in_len_q  [NUM_LAYERS];
    logic [NRN_W-1:0] num_nrn_q [NUM_LAYERS];

    // NOTE: the table is small and a cleared table must read as "skip every
    // layer", so it is reset like ordinary flops rather than left as RAM.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                in_len_q[i]  <= '0;
                num_nrn_q[i] <= '0;
            end
        end else if (we && (int'(wr_layer) < NUM_LAYERS)) begin
            in_len_q[wr_layer]  <= wr_in_len;
            num_nrn_q[wr_layer] <= wr_num_nrn;
        end
    end

    // NOTE: defaults first so the out-of-range path cannot infer a latch.
    always_comb begin
        rd_in_len  = '0;
        rd_num_nrn = '0;
        if (int'(rd_layer) < NUM_LAYERS) begin
            rd_in_len  = in_len_q[rd_layer];
            rd_num_nrn = num_nrn_q[rd_layer];
        end
    end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one PE through a multi-layer MLP pass neuron by neuron:
// weight-bank swap, activation streaming, pipeline drain, result strobe.
module mlp_layer_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int LEN_W      = 8,
    parameter int NRN_W      = 8,
    parameter int PIPE_LAT   = PIPE_LAT_DEFAULT,
    localparam int LAYER_W   = layer_w(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               cfg_we,
    input  logic [LAYER_W-1:0] cfg_layer,
    input  logic [LEN_W-1:0]   cfg_in_len,
    input  logic [NRN_W-1:0]   cfg_num_nrn,
    input  logic               wbank_ready,
    output logic               wbank_swap,
    input  logic               iact_valid,
    output logic               iact_ready,
    output logic               mac_en,
    output logic               acc_clr,
    output logic               out_valid,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [NRN_W-1:0]   neuron_idx,
    output logic [LEN_W-1:0]   in_idx
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [DRN_W-1:0]   LAST_DRAIN = DRN_W'(PIPE_LAT - 1);

    state_t             state, state_nxt;
    logic [LAYER_W-1:0] layer_q, layer_nxt;
    logic [NRN_W-1:0]   nrn_q, nrn_nxt;
    logic [LEN_W-1:0]   idx_q, idx_nxt;
    logic [DRN_W-1:0]   drain_q, drain_nxt;

    logic [LEN_W-1:0]   cur_in_len;
    logic [NRN_W-1:0]   cur_num_nrn;
    logic               in_last;
    logic               nrn_last;

    mlp_cfg_regfile #(
        .NUM_LAYERS (NUM_LAYERS),
        .LEN_W      (LEN_W),
        .NRN_W      (NRN_W)
    ) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .we         (cfg_we && (state == S_IDLE)),
        .wr_layer   (cfg_layer),
        .wr_in_len  (cfg_in_len),
        .wr_num_nrn (cfg_num_nrn),
        .rd_layer   (layer_q),
        .rd_in_len  (cur_in_len),
        .rd_num_nrn (cur_num_nrn)
    );

    // Only evaluated once SKIPCHK has ruled out zero lengths.
    assign in_last  = (idx_q == cur_in_len - LEN_W'(1));
    assign nrn_last = (nrn_q == cur_num_nrn - NRN_W'(1));

    assign layer_idx  = layer_q;
    assign neuron_idx = nrn_q;
    assign in_idx     = idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            layer_q <= '0;
            nrn_q   <= '0;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state   <= state_nxt;
            layer_q <= layer_nxt;
            nrn_q   <= nrn_nxt;
            idx_q   <= idx_nxt;
            drain_q <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        layer_nxt  = layer_q;
        nrn_nxt    = nrn_q;
        idx_nxt    = idx_q;
        drain_nxt  = '0;
        busy       = 1'b1;
        done       = 1'b0;
        wbank_swap = 1'b0;
        acc_clr    = 1'b0;
        iact_ready = 1'b0;
        mac_en     = 1'b0;
        out_valid  = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    layer_nxt = '0;
                    nrn_nxt   = '0;
                    state_nxt = S_SKIPCHK;
                end
            end
            S_SKIPCHK: begin
                if ((cur_in_len == '0) || (cur_num_nrn == '0)) state_nxt = S_LAYER_END;
                else                                           state_nxt = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (wbank_ready) begin
                    wbank_swap = 1'b1;
                    acc_clr    = 1'b1;
                    idx_nxt    = '0;
                    state_nxt  = S_MAC;
                end
            end
            S_MAC: begin
                iact_ready = 1'b1;
                mac_en     = iact_valid;
                if (iact_valid) begin
                    // The last address is held through the drain.
                    if (in_last) state_nxt = (PIPE_LAT > 0) ? S_DRAIN : S_EMIT;
                    else         idx_nxt   = idx_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                drain_nxt = drain_q + DRN_W'(1);
                if (drain_q == LAST_DRAIN) begin
                    drain_nxt = '0;
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (nrn_last) begin
                    state_nxt = S_LAYER_END;
                end else begin
                    nrn_nxt   = nrn_q + NRN_W'(1);
                    state_nxt = S_WAIT_W;
                end
            end
            S_LAYER_END: begin
                if (layer_q == LAST_LAYER) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    layer_nxt = layer_q + LAYER_W'(1);
                    nrn_nxt   = '0;
                    state_nxt = S_SKIPCHK;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    a_swap_pulse: assert property (@(posedge clk) disable iff (rst) wbank_swap |=> !wbank_swap);
    a_ov_pulse:   assert property (@(posedge clk) disable iff (rst) out_valid |=> !out_valid);
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
